// File: rtl/multdiv_sequencer.sv
// Stalls decode around mul/div, pulses the iterative multdiv unit and writes back the result or an exception code.
// Latency: at least 4 cycles (detect, START, BUSY, WB); stall drops in WB; the BUSY timeout forces an exception.
module multdiv_sequencer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        inst_valid,
    input  logic [4:0]  inst_opcode,
    input  logic [4:0]  inst_aluop,
    input  logic [4:0]  inst_rd,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        stall,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_operand_a,
    output logic [31:0] md_operand_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    typedef enum logic [1:0] {IDLE, START, BUSY, WB} state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic [31:0] op_a, op_b, res_q;
    logic [4:0]  rd_q;
    logic        is_div, exc_q;
    logic        detect;

    assign detect = inst_valid && (inst_opcode == 5'b00000) &&
                    ((inst_aluop == 5'b00110) || (inst_aluop == 5'b00111));

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = detect;
                if (detect) state_nxt = START;
            end
            START: begin
                stall     = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                if (md_ready || (cnt == LAST_CNT)) state_nxt = WB;
            end
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            op_a   <= 32'd0;
            op_b   <= 32'd0;
            res_q  <= 32'd0;
            rd_q   <= 5'd0;
            is_div <= 1'b0;
            exc_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (detect) begin
                        op_a   <= operand_a;
                        op_b   <= operand_b;
                        rd_q   <= inst_rd;
                        is_div <= inst_aluop[0];
                        res_q  <= 32'd0;
                        exc_q  <= 1'b0;
                    end
                end
                START: cnt <= 8'd0;
                BUSY: begin
                    // A ready arriving on the final allowed cycle still beats the timeout.
                    if (md_ready) begin
                        res_q <= md_result;
                        exc_q <= md_exception;
                    end else if (cnt == LAST_CNT) begin
                        exc_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign md_ctrl_mult = (state == START) && !is_div;
    assign md_ctrl_div  = (state == START) && is_div;
    assign md_operand_a = op_a;
    assign md_operand_b = op_b;

    // Exceptions report to rstatus ($r30): code 4 for mul, 5 for div.
    assign wb_we   = (state == WB) && (exc_q || (rd_q != 5'd0));
    assign wb_rd   = (state != WB) ? 5'd0 : (exc_q ? 5'd30 : rd_q);
    assign wb_data = (state != WB) ? 32'd0 :
                     (exc_q ? (is_div ? 32'd5 : 32'd4) : res_q);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed and randomized bench for multdiv_sequencer against a per-operation timeline model.
module tb_multdiv_sequencer;

    localparam int TMO = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        inst_valid = 1'b0;
    logic [4:0]  inst_opcode = 5'd0;
    logic [4:0]  inst_aluop = 5'd0;
    logic [4:0]  inst_rd = 5'd0;
    logic [31:0] operand_a = 32'd0;
    logic [31:0] operand_b = 32'd0;
    logic        stall;
    logic        md_ctrl_mult, md_ctrl_div;
    logic [31:0] md_operand_a, md_operand_b;
    logic [31:0] md_result = 32'd0;
    logic        md_exception = 1'b0;
    logic        md_ready = 1'b0;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    multdiv_sequencer #(.TIMEOUT(TMO)) dut (
        .clock(clock), .reset_n(reset_n),
        .inst_valid(inst_valid), .inst_opcode(inst_opcode), .inst_aluop(inst_aluop),
        .inst_rd(inst_rd), .operand_a(operand_a), .operand_b(operand_b),
        .stall(stall), .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
        .md_operand_a(md_operand_a), .md_operand_b(md_operand_b),
        .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Checks that no stall, pulse or write appears; optionally pulses md_ready while idle.
    task automatic idle_cycles(input int n, input bit ready_pulse);
        for (int i = 0; i < n; i++) begin
            inst_valid   = 1'($urandom_range(0, 1));
            inst_opcode  = 5'b00101;
            inst_aluop   = 5'b00110;
            md_ready     = ready_pulse;
            md_result    = $urandom;
            md_exception = 1'($urandom_range(0, 1));
            #1;
            check("idle_stall", 32'(stall), 32'd0);
            check("idle_pulse", {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd0);
            check("idle_we", 32'(wb_we), 32'd0);
            next_cycle();
        end
        inst_valid = 1'b0;
        md_ready   = 1'b0;
    endtask

    task automatic passthrough(input logic [4:0] opc, input logic [4:0] aop, input logic vld);
        inst_valid  = vld;
        inst_opcode = opc;
        inst_aluop  = aop;
        inst_rd     = 5'd3;
        #1;
        check("pass_stall", 32'(stall), 32'd0);
        check("pass_pulse", {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd0);
        check("pass_we", 32'(wb_we), 32'd0);
        next_cycle();
        inst_valid = 1'b0;
    endtask

    // One md instruction presented in relative cycle 0. k = cycle md_ready is seen
    // (outside 2..TMO+1 means it never arrives and the timeout fires).
    task automatic run_op(input bit dv, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int k, input logic [31:0] res,
                          input bit exc, input bit start_glitch);
        bit tmo, xe;
        int wbc;
        logic [31:0] exp_data;
        tmo = !(k >= 2 && k <= TMO + 1);
        wbc = tmo ? TMO + 2 : k + 1;
        xe  = tmo || exc;
        exp_data = xe ? (dv ? 32'd5 : 32'd4) : res;
        for (int c = 0; c <= wbc; c++) begin
            inst_valid   = 1'b1;
            inst_opcode  = 5'b00000;
            inst_aluop   = dv ? 5'b00111 : 5'b00110;
            inst_rd      = rd;
            operand_a    = (c == 0) ? a : $urandom;
            operand_b    = (c == 0) ? b : $urandom;
            md_ready     = (!tmo && c == k) || (start_glitch && c == 1);
            md_result    = (!tmo && c == k) ? res : $urandom;
            md_exception = (!tmo && c == k) ? exc : (start_glitch && c == 1);
            #1;
            check("stall", 32'(stall), 32'(c < wbc));
            check("mult_pulse", 32'(md_ctrl_mult), 32'(c == 1 && !dv));
            check("div_pulse", 32'(md_ctrl_div), 32'(c == 1 && dv));
            if (c >= 1) begin
                check("md_op_a", md_operand_a, a);
                check("md_op_b", md_operand_b, b);
            end
            check("wb_we", 32'(wb_we), (c == wbc) ? 32'(xe || rd != 5'd0) : 32'd0);
            check("wb_rd", 32'(wb_rd), (c == wbc) ? (xe ? 32'd30 : 32'(rd)) : 32'd0);
            check("wb_data", wb_data, (c == wbc) ? exp_data : 32'd0);
            next_cycle();
        end
        inst_valid   = 1'b0;
        md_ready     = 1'b0;
        md_exception = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_pulse", {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd0);
        check("rst_op_a", md_operand_a, 32'd0);
        check("rst_op_b", md_operand_b, 32'd0);
        check("rst_wb", {26'd0, wb_we, wb_rd}, 32'd0);
        check("rst_data", wb_data, 32'd0);
        next_cycle();

        run_op(1'b0, 32'd6, 32'd7, 5'd5, 4, 32'd42, 1'b0, 1'b0);
        idle_cycles(1, 1'b0);
        run_op(1'b1, 32'd9, 32'd0, 5'd4, 3, 32'd0, 1'b1, 1'b0);
        idle_cycles(1, 1'b0);
        run_op(1'b0, 32'd2, 32'd3, 5'd8, 0, 32'd0, 1'b0, 1'b0);
        idle_cycles(1, 1'b0);
        idle_cycles(1, 1'b1);
        run_op(1'b0, 32'd9, 32'd11, 5'd0, 4, 32'd99, 1'b0, 1'b0);
        passthrough(5'b00101, 5'b00110, 1'b1);
        passthrough(5'b00000, 5'b00000, 1'b1);
        passthrough(5'b00000, 5'b00111, 1'b0);
        run_op(1'b1, 32'd100, 32'd7, 5'd12, TMO + 1, 32'd14, 1'b0, 1'b1);

        // Reset in the third BUSY cycle aborts with no writeback.
        for (int c = 0; c <= 4; c++) begin
            inst_valid  = 1'b1;
            inst_opcode = 5'b00000;
            inst_aluop  = 5'b00110;
            inst_rd     = 5'd7;
            operand_a   = 32'd11;
            operand_b   = 32'd13;
            reset_n     = (c != 4);
            #1;
            check("abort_stall", 32'(stall), 32'd1);
            next_cycle();
        end
        reset_n      = 1'b1;
        inst_valid   = 1'b0;
        md_ready     = 1'b1;
        md_result    = 32'd77;
        #1;
        check("abort_stall_after", 32'(stall), 32'd0);
        check("abort_pulse", {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd0);
        check("abort_op_a", md_operand_a, 32'd0);
        check("abort_op_b", md_operand_b, 32'd0);
        check("abort_wb", {26'd0, wb_we, wb_rd}, 32'd0);
        check("abort_data", wb_data, 32'd0);
        next_cycle();
        idle_cycles(2, 1'b0);
        run_op(1'b0, 32'd3, 32'd3, 5'd9, 4, 32'd9, 1'b0, 1'b0);

        // Back-to-back mul then div with one IDLE cycle between.
        run_op(1'b0, 32'd4, 32'd5, 5'd1, 6, 32'd20, 1'b0, 1'b0);
        idle_cycles(1, 1'b0);
        run_op(1'b1, 32'd20, 32'd4, 5'd2, 6, 32'd5, 1'b0, 1'b0);

        for (int n = 0; n < 25; n++) begin
            run_op(1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                   int'($urandom_range(2, TMO + 3)), $urandom,
                   ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            idle_cycles(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
